// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter and its BCD converter.
package freq_meter_pkg;

    localparam int          COUNT_W       = 27;
    localparam int          BCD_DIGITS    = 8;
    localparam int          BCD_W         = 4 * BCD_DIGITS;
    localparam int          SHIFT_CNT_W   = $clog2(COUNT_W);
    localparam int unsigned DEF_CLK_HZ    = 50_000_000;
    localparam int unsigned DEF_MAX_COUNT = 99_999_999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] digits);
        logic [BCD_W-1:0] adj;
        adj = digits;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per cycle, result and
// done pulse on the cycle after the last shift. A new start aborts any
// conversion in flight and the old result is never published.
module bin2bcd_seq
    import freq_meter_pkg::*;
(
    input  logic               fin,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] bin,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);

    conv_state_t            state;
    conv_state_t            state_next;
    logic [BCD_W-1:0]       digits;
    logic [COUNT_W-1:0]     bits;
    logic [SHIFT_CNT_W-1:0] shift_cnt;
    logic                   last_shift;
    logic                   load_result;

    assign last_shift = (shift_cnt == SHIFT_CNT_W'(COUNT_W - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start always (re)enters SHIFT.
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = SHIFT;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                SHIFT:   state_next = last_shift ? DONE : SHIFT;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode: publish only when DONE is not being pre-empted.
    always_comb begin
        load_result = (state == DONE) && !start;
    end

    // Working register: load on start, adjust-then-shift once per SHIFT cycle.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            digits    <= '0;
            bits      <= '0;
            shift_cnt <= '0;
        end else if (start) begin
            digits    <= '0;
            bits      <= bin;
            shift_cnt <= '0;
        end else if (state == SHIFT) begin
            {digits, bits} <= {dabble_adjust(digits), bits} << 1;
            shift_cnt      <= shift_cnt + 1'b1;
        end
    end

    // Result register and one-cycle completion pulse.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= load_result;
            if (load_result) begin
                bcd <= digits;
            end
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous input over a
// window of CLK_HZ reference cycles and reports the count in binary and BCD.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned MAX_COUNT = DEF_MAX_COUNT
) (
    input  logic               fin,
    input  logic               rst_n,
    input  logic               sig_in,
    output logic [COUNT_W-1:0] freq,
    output logic               freq_valid,
    output logic               ovf,
    output logic [BCD_W-1:0]   bcd,
    output logic               bcd_valid
);

    localparam int                 GATE_W    = $clog2(CLK_HZ + 1);
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(CLK_HZ);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_COUNT);

    logic               sync_meta;
    logic               sync_q;
    logic               sync_prev;
    logic               sig_edge;
    logic [GATE_W-1:0]  gate;
    logic               gate_last;
    logic [COUNT_W-1:0] edge_cnt;
    logic [COUNT_W-1:0] edge_cnt_next;

    // Two-flop synchronizer plus one flop of history for rising-edge detect.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_meta <= sig_in;
            sync_q    <= sync_meta;
            sync_prev <= sync_q;
        end
    end

    assign sig_edge  = sync_q & ~sync_prev;
    assign gate_last = (gate == GATE_LAST);

    // Count including this cycle's edge, held at the saturation limit.
    always_comb begin
        edge_cnt_next = edge_cnt;
        if (sig_edge && (edge_cnt != COUNT_MAX)) begin
            edge_cnt_next = edge_cnt + 1'b1;
        end
    end

    // Gate counter runs 1..CLK_HZ; the edge counter restarts on the terminal cycle.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            gate     <= GATE_W'(1);
            edge_cnt <= '0;
        end else if (gate_last) begin
            gate     <= GATE_W'(1);
            edge_cnt <= '0;
        end else begin
            gate     <= gate + 1'b1;
            edge_cnt <= edge_cnt_next;
        end
    end

    // Publish the closing window's count, overflow flag and valid pulse.
    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            freq       <= '0;
            ovf        <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= gate_last;
            if (gate_last) begin
                freq <= edge_cnt_next;
                ovf  <= (edge_cnt_next == COUNT_MAX);
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .fin   (fin),
        .rst_n (rst_n),
        .start (freq_valid),
        .bin   (freq),
        .bcd   (bcd),
        .done  (bcd_valid)
    );

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: three parameterisations share one input,
// each compared cycle by cycle against a window-level model of the meter.
`timescale 1ns/1ps
module tb_freq_meter;
    import freq_meter_pkg::*;

    localparam int NDUT = 3;
    localparam int HMAX = 2048;
    localparam int LAT  = 29;

    logic fin = 1'b0;
    logic rst_n;
    logic sig_in;

    logic [NDUT-1:0][COUNT_W-1:0] o_freq;
    logic [NDUT-1:0]              o_fv;
    logic [NDUT-1:0]              o_ovf;
    logic [NDUT-1:0][BCD_W-1:0]   o_bcd;
    logic [NDUT-1:0]              o_bv;

    logic               conv_start;
    logic [COUNT_W-1:0] conv_bin;
    logic [BCD_W-1:0]   conv_bcd;
    logic               conv_done;

    int vectors     = 0;
    int miscompares = 0;

    // model state
    int               cyc;
    bit               hist [HMAX];
    int               mode;
    int               phase;
    int               pulse_at;
    int               exp_freq [NDUT];
    bit               exp_ovf  [NDUT];
    logic [BCD_W-1:0] exp_bcd  [NDUT];
    bit               pend     [NDUT];
    int               due      [NDUT];
    logic [BCD_W-1:0] pval     [NDUT];

    always #10 fin = ~fin;

    freq_meter #(.CLK_HZ(100), .MAX_COUNT(99)) dut (
        .fin(fin), .rst_n(rst_n), .sig_in(sig_in),
        .freq(o_freq[0]), .freq_valid(o_fv[0]), .ovf(o_ovf[0]),
        .bcd(o_bcd[0]), .bcd_valid(o_bv[0])
    );

    freq_meter #(.CLK_HZ(100), .MAX_COUNT(40)) dut_sat (
        .fin(fin), .rst_n(rst_n), .sig_in(sig_in),
        .freq(o_freq[1]), .freq_valid(o_fv[1]), .ovf(o_ovf[1]),
        .bcd(o_bcd[1]), .bcd_valid(o_bv[1])
    );

    freq_meter #(.CLK_HZ(20), .MAX_COUNT(99)) dut_fast (
        .fin(fin), .rst_n(rst_n), .sig_in(sig_in),
        .freq(o_freq[2]), .freq_valid(o_fv[2]), .ovf(o_ovf[2]),
        .bcd(o_bcd[2]), .bcd_valid(o_bv[2])
    );

    bin2bcd_seq u_conv (
        .fin(fin), .rst_n(rst_n), .start(conv_start),
        .bin(conv_bin), .bcd(conv_bcd), .done(conv_done)
    );

    function automatic int clk_of(int d);
        return (d == 2) ? 20 : 100;
    endfunction

    function automatic int max_of(int d);
        return (d == 1) ? 40 : 99;
    endfunction

    function automatic bit sample_at(int n);
        return (n >= 1 && n < HMAX) ? hist[n] : 1'b0;
    endfunction

    // The meter sees a 0->1 change of the input two reference cycles late.
    function automatic int edges_seen(int n);
        return (sample_at(n - 2) && !sample_at(n - 3)) ? 1 : 0;
    endfunction

    function automatic int window_count(int w, int c, int mx);
        int s;
        s = 0;
        for (int n = (w - 1) * c + 1; n <= w * c; n++) s += edges_seen(n);
        return (s > mx) ? mx : s;
    endfunction

    function automatic logic [BCD_W-1:0] to_bcd(int v);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic stim(int n);
        case (mode)
            1:       return (((n + phase) / 5) % 2) == 1;
            2:       return (n % 2) == 1;
            3:       return $urandom_range(0, 1) == 1;
            4:       return n == pulse_at;
            default: return 1'b0;
        endcase
    endfunction

    // One reference cycle: drive at negedge, record the sample, return at negedge.
    task automatic step();
        sig_in = stim(cyc + 1);
        @(posedge fin);
        if (rst_n) begin
            cyc++;
            if (cyc < HMAX) hist[cyc] = sig_in;
        end
        @(negedge fin);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge fin);
        cyc = 0;
        foreach (hist[i]) hist[i] = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            exp_freq[d] = 0;
            exp_ovf[d]  = 1'b0;
            exp_bcd[d]  = '0;
            pend[d]     = 1'b0;
            due[d]      = 0;
            pval[d]     = '0;
        end
        rst_n = 1'b1;
    endtask

    // Advance ncyc cycles, comparing every meter against the window model.
    task automatic run(input int ncyc);
        bit fv_exp;
        bit bv_exp;
        for (int k = 0; k < ncyc; k++) begin
            step();
            for (int d = 0; d < NDUT; d++) begin
                fv_exp = (cyc > 0) && ((cyc % clk_of(d)) == 0);
                if (fv_exp) begin
                    exp_freq[d] = window_count(cyc / clk_of(d), clk_of(d), max_of(d));
                    exp_ovf[d]  = (exp_freq[d] == max_of(d));
                    pend[d]     = 1'b1;
                    due[d]      = cyc + LAT;
                    pval[d]     = to_bcd(exp_freq[d]);
                end
                bv_exp = pend[d] && (cyc == due[d]);
                if (bv_exp) begin
                    exp_bcd[d] = pval[d];
                    pend[d]    = 1'b0;
                end
                vectors++;
                if (o_fv[d] !== fv_exp || o_freq[d] !== COUNT_W'(exp_freq[d]) ||
                    o_ovf[d] !== exp_ovf[d] || o_bv[d] !== bv_exp || o_bcd[d] !== exp_bcd[d]) begin
                    miscompares++;
                    $display("FAIL window dut%0d cyc=%0d: got fv=%b freq=%0d ovf=%b bv=%b bcd=%h, want fv=%b freq=%0d ovf=%b bv=%b bcd=%h",
                             d, cyc, o_fv[d], o_freq[d], o_ovf[d], o_bv[d], o_bcd[d],
                             fv_exp, exp_freq[d], exp_ovf[d], bv_exp, exp_bcd[d]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge fin);
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if ({o_fv[d], o_freq[d], o_ovf[d], o_bcd[d], o_bv[d]} !== '0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got fv=%b freq=%0d ovf=%b bcd=%h bv=%b, want all zero",
                         d, o_fv[d], o_freq[d], o_ovf[d], o_bcd[d], o_bv[d]);
            end
        end
        apply_reset();
        mode = 3;
        run(100);
        vectors++;
        if (o_fv[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL first_window: got freq_valid=%b at cycle 100, want 1", o_fv[0]);
        end
    endtask

    task automatic test_square();
        apply_reset();
        mode  = 1;
        phase = $urandom_range(0, 9);
        run(200);
        vectors++;
        if (o_freq[0] !== 27'd10 || o_ovf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL square_freq: got freq=%0d ovf=%b, want 10 0", o_freq[0], o_ovf[0]);
        end
        run(LAT);
        vectors++;
        if (o_bv[0] !== 1'b1 || o_bcd[0] !== 32'h0000_0010) begin
            miscompares++;
            $display("FAIL square_bcd: got bv=%b bcd=%h, want 1 00000010", o_bv[0], o_bcd[0]);
        end
        run(71);
    endtask

    task automatic test_idle_low();
        apply_reset();
        mode = 0;
        run(100);
        vectors++;
        if (o_fv[0] !== 1'b1 || o_freq[0] !== 27'd0) begin
            miscompares++;
            $display("FAIL idle_freq: got fv=%b freq=%0d, want 1 0", o_fv[0], o_freq[0]);
        end
        run(LAT);
        vectors++;
        if (o_bv[0] !== 1'b1 || o_bcd[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_bcd: got bv=%b bcd=%h, want 1 00000000", o_bv[0], o_bcd[0]);
        end
        run(71);
        vectors++;
        if (o_fv[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_period: got freq_valid=%b at cycle 200, want 1", o_fv[0]);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        mode = 2;
        run(200);
        vectors++;
        if (o_freq[0] !== 27'd50 || o_ovf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle_freq: got freq=%0d ovf=%b, want 50 0", o_freq[0], o_ovf[0]);
        end
        vectors++;
        if (o_freq[1] !== 27'd40 || o_ovf[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL saturate_freq: got freq=%0d ovf=%b, want 40 1", o_freq[1], o_ovf[1]);
        end
        run(LAT);
        vectors++;
        if (o_bcd[1] !== 32'h0000_0040 || o_bcd[0] !== 32'h0000_0050) begin
            miscompares++;
            $display("FAIL saturate_bcd: got sat=%h full=%h, want 00000040 00000050", o_bcd[1], o_bcd[0]);
        end
    endtask

    task automatic test_terminal_edge();
        apply_reset();
        mode     = 4;
        pulse_at = 98;
        run(100);
        vectors++;
        if (o_fv[0] !== 1'b1 || o_freq[0] !== 27'd1) begin
            miscompares++;
            $display("FAIL terminal_edge: got fv=%b freq=%0d, want 1 1", o_fv[0], o_freq[0]);
        end
        run(100);
        vectors++;
        if (o_fv[0] !== 1'b1 || o_freq[0] !== 27'd0) begin
            miscompares++;
            $display("FAIL terminal_next: got fv=%b freq=%0d, want 1 0", o_fv[0], o_freq[0]);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        mode  = 1;
        phase = $urandom_range(0, 9);
        run(260);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if ({o_fv[d], o_freq[d], o_ovf[d], o_bcd[d], o_bv[d]} !== '0) begin
                miscompares++;
                $display("FAIL mid_reset dut%0d: got fv=%b freq=%0d ovf=%b bcd=%h bv=%b, want all zero",
                         d, o_fv[d], o_freq[d], o_ovf[d], o_bcd[d], o_bv[d]);
            end
        end
        @(negedge fin);
        apply_reset();
        mode = 3;
        run(100);
        vectors++;
        if (o_fv[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_window: got freq_valid=%b at cycle 100, want 1", o_fv[0]);
        end
        run(100);
    endtask

    task automatic test_random();
        apply_reset();
        mode = 3;
        run(400);
    endtask

    task automatic test_back_to_back();
        logic [COUNT_W-1:0] v0, v1, v2;
        logic [BCD_W-1:0]   held;
        v0 = COUNT_W'($urandom_range(0, 99_999_999));
        v1 = COUNT_W'($urandom_range(0, 99_999_999));
        v2 = COUNT_W'($urandom_range(0, 99_999_999));
        conv_bin   = v0;
        conv_start = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge fin);
            if (k == 1) conv_start = 1'b0;
            if (k >= 28) begin
                vectors++;
                if (conv_done !== (k == LAT)) begin
                    miscompares++;
                    $display("FAIL single_latency k=%0d: got done=%b, want %b", k, conv_done, k == LAT);
                end
            end
        end
        held = to_bcd(int'(v0));
        vectors++;
        if (conv_bcd !== held) begin
            miscompares++;
            $display("FAIL single_bcd: got %h, want %h for %0d", conv_bcd, held, v0);
        end
        conv_bin   = v1;
        conv_start = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            @(negedge fin);
            if (k == 1) conv_start = 1'b0;
            if (k == 20) begin
                conv_bin   = v2;
                conv_start = 1'b1;
            end
            if (k == 21) conv_start = 1'b0;
            vectors++;
            if (conv_done !== (k == 20 + LAT) ||
                conv_bcd !== ((k >= 20 + LAT) ? to_bcd(int'(v2)) : held)) begin
                miscompares++;
                $display("FAIL back_to_back k=%0d: got done=%b bcd=%h, want done=%b bcd=%h",
                         k, conv_done, conv_bcd, k == 20 + LAT,
                         (k >= 20 + LAT) ? to_bcd(int'(v2)) : held);
            end
        end
    endtask

    initial begin
        cyc        = 0;
        mode       = 0;
        phase      = 0;
        pulse_at   = 0;
        conv_start = 1'b0;
        conv_bin   = '0;
        test_reset();
        test_square();
        test_idle_low();
        test_saturation();
        test_terminal_edge();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, giving the reference clock cycles per gate window (1 s gate).
REQ-002 The block SHALL have parameter MAX_COUNT, default 99999999, giving the saturation limit of the edge count (8 decimal digits).
REQ-003 The block SHALL have port fin, input, 1 bit: the single clock, 50 MHz board clock, with all logic on posedge fin.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous, active-low.
REQ-005 The block SHALL have port sig_in, input, 1 bit: the external signal under measurement, asynchronous to fin.
REQ-006 The block SHALL have port freq, output, 27 bits: the binary edge count of the last completed gate window, in Hz.
REQ-007 The block SHALL have port freq_valid, output, 1 bit: a one-cycle pulse when freq updates.
REQ-008 The block SHALL have port ovf, output, 1 bit: set when the last window's count hit MAX_COUNT.
REQ-009 The block SHALL have port bcd, output, 32 bits: 8 packed BCD digits of freq, with the LS digit in bits [3:0].
REQ-010 The block SHALL have port bcd_valid, output, 1 bit: a one-cycle pulse when bcd updates.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected as sync=1 while the previous sync=0.
REQ-012 The gate counter SHALL count 1..CLK_HZ; the terminal cycle is gate=CLK_HZ, and the counter SHALL wrap to 1 on the next cycle.
REQ-013 The edge counter SHALL increment by 1 per detected edge and SHALL saturate at MAX_COUNT, never wrapping.
REQ-014 On the terminal gate cycle, freq SHALL load the edge count including any edge detected in that same cycle, and freq_valid SHALL pulse in the following cycle, together with the updated freq.
REQ-015 On the terminal gate cycle, the edge counter SHALL restart at 0, and an edge in that cycle SHALL NOT be counted in the next window.
REQ-016 ovf SHALL load (count==MAX_COUNT) along with freq, and SHALL hold until the next window closes.
REQ-017 The binary-to-BCD converter SHALL be a double-dabble FSM with states IDLE, SHIFT and DONE.
REQ-018 IDLE -> SHIFT on freq_valid.
REQ-019 SHIFT SHALL run exactly 27 cycles, one bit per cycle, with add-3 to any digit >=5 before each shift.
REQ-020 SHIFT -> DONE after the 27th shift; DONE SHALL load bcd, pulse bcd_valid for 1 cycle, then go to IDLE.
REQ-021 bcd_valid SHALL follow freq_valid by exactly 29 cycles.
REQ-022 If freq_valid arrives while in SHIFT or DONE, the converter SHALL restart in SHIFT with the new freq, suppress bcd_valid for the aborted conversion, and leave bcd holding its previous value.
REQ-023 The first window after reset SHALL be a full CLK_HZ cycles; no partial-window result SHALL be reported.

Reset
REQ-024 With rst_n=0, the block SHALL asynchronously clear synchronizer flops, edge history, gate counter to 1, edge counter, freq, ovf, freq_valid, bcd and bcd_valid to 0, and the FSM to IDLE.
REQ-025 Reset mid-window or mid-conversion SHALL discard all partial results, and after release outputs SHALL stay 0 until the first full window completes.
REQ-026 The first posedge fin after rst_n rises SHALL count as gate cycle 1.

Structure
REQ-027 Package freq_meter_pkg SHALL hold the FSM state enum (IDLE/SHIFT/DONE), COUNT_W=27, BCD_DIGITS=8 and the default CLK_HZ/MAX_COUNT constants.
REQ-028 The converter SHALL be sub-module bin2bcd_seq, with ports fin, rst_n, start, bin[26:0], bcd[31:0] and done.
REQ-029 The synchronizer and edge detection SHALL stay inline.

Verification (CLK_HZ=100, MAX_COUNT=99 for sim)
REQ-030 Scenario: sig_in square wave with period 10 fin cycles, phase-locked -> each freq_valid gives freq=10, ovf=0, and bcd=32'h00000010 exactly 29 cycles later.
REQ-031 Scenario: sig_in held 0 -> freq=0, bcd=0, with freq_valid every 100 cycles.
REQ-032 Scenario: sig_in toggling every fin cycle -> 50 edges counted, freq=50; set MAX_COUNT=40 -> freq=40, ovf=1.
REQ-033 Scenario: single edge placed in the terminal gate cycle -> counted in the closing window (freq=1); the next window shows freq=0.
REQ-034 Scenario: rst_n pulsed low at gate count 60 with 6 edges counted -> all outputs 0; the first freq_valid comes 100 cycles after release and reflects post-reset edges only.
REQ-035 Scenario: CLK_HZ=20 with forced back-to-back windows (freq_valid at cycles 0 and 20) -> the first conversion aborts with no bcd_valid; bcd_valid comes 29 cycles after the second freq_valid, with the second value.
